// File: rtl/timer_pkg.sv
// Shared BCD constants and helpers for the stopwatch/timer datapath.
package timer_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam int MAX_DIGITS = 8;

  function automatic logic is_bcd(input logic [BCD_W-1:0] nibble);
    return nibble <= BCD_MAX;
  endfunction

  // True when each of the lowest n digits of value equals digit.
  function automatic logic bcd_all(input logic [MAX_DIGITS*BCD_W-1:0] value,
                                   input logic [BCD_W-1:0] digit,
                                   input int n);
    logic hit;
    hit = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n && value[i*BCD_W +: BCD_W] != digit) hit = 1'b0;
    end
    return hit;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Command/status bundle between the timebase, the BCD counter and the display mux.
interface bcd_updown_counter_if #(parameter int DIGITS = 4);

  logic                  En;
  logic                  Up;
  logic                  Clear;
  logic                  Load;
  logic [4*DIGITS-1:0]   LoadVal;
  logic                  Lap;
  logic [4*DIGITS-1:0]   Count;
  logic [4*DIGITS-1:0]   LapValue;
  logic                  Rollover;
  logic                  AtMax;
  logic                  AtZero;
  logic                  LoadErr;

  modport master (
    output En, Up, Clear, Load, LoadVal, Lap,
    input  Count, LapValue, Rollover, AtMax, AtZero, LoadErr
  );

  modport slave (
    input  En, Up, Clear, Load, LoadVal, Lap,
    output Count, LapValue, Rollover, AtMax, AtZero, LoadErr
  );

endinterface

// File: rtl/bcd_digit.sv
// One decimal digit of the cascade: clear, validated load, and up/down step.
module bcd_digit
  import timer_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             step,
  input  logic             up,
  output logic [BCD_W-1:0] value,
  output logic             carry_out
);

  logic [BCD_W-1:0] next_val;

  // Codes above 9 only appear through a fault; they carry like 9 and step to 0.
  assign carry_out = up ? (value >= BCD_MAX) : (value == '0);

  always_comb begin
    next_val = value;
    if (clr) begin
      next_val = '0;
    end else if (ld) begin
      next_val = is_bcd(ld_val) ? ld_val : '0;
    end else if (step) begin
      if (up) begin
        next_val = (value >= BCD_MAX) ? '0 : value + 4'd1;
      end else if (value == '0) begin
        next_val = BCD_MAX;
      end else if (value > BCD_MAX) begin
        next_val = '0;
      end else begin
        next_val = value - 4'd1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) value <= '0;
    else       value <= next_val;
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Parametrised BCD up/down counter with lap capture, wrap/saturate limit and load validation.
module bcd_updown_counter
  import timer_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
)(
  input logic Clk,
  input logic Reset,
  bcd_updown_counter_if.slave bus
);

  localparam int W  = BCD_W * DIGITS;
  localparam int PW = MAX_DIGITS * BCD_W;

  logic [DIGITS-1:0] carry;
  logic [DIGITS-1:0] step;
  logic [W-1:0]      count;
  logic [W-1:0]      lap_q;
  logic              rollover_q;
  logic              load_err_q;
  logic              at_limit;
  logic              wrap_evt;
  logic              step_en;
  logic              load_bad;

  // Every digit carrying means the whole count sits at all-9s (up) or all-0s (down).
  assign at_limit = &carry;
  assign wrap_evt = bus.En && at_limit;
  assign step_en  = bus.En && (WRAP || !at_limit);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_first
      assign step[k] = step_en;
    end else begin : g_rest
      assign step[k] = step[k-1] && carry[k-1];
    end

    bcd_digit u_digit (
      .Clk       (Clk),
      .Reset     (Reset),
      .clr       (bus.Clear),
      .ld        (bus.Load),
      .ld_val    (bus.LoadVal[k*BCD_W +: BCD_W]),
      .step      (step[k]),
      .up        (bus.Up),
      .value     (count[k*BCD_W +: BCD_W]),
      .carry_out (carry[k])
    );
  end

  always_comb begin
    load_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(bus.LoadVal[i*BCD_W +: BCD_W])) load_bad = 1'b1;
    end
  end

  // Status pulses follow the same Clear > Load > En priority as the digits.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rollover_q <= 1'b0;
      load_err_q <= 1'b0;
    end else if (bus.Clear) begin
      rollover_q <= 1'b0;
      load_err_q <= 1'b0;
    end else if (bus.Load) begin
      rollover_q <= 1'b0;
      load_err_q <= load_bad;
    end else begin
      rollover_q <= WRAP && wrap_evt;
      load_err_q <= 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)        lap_q <= '0;
    else if (bus.Lap) lap_q <= count;
  end

  assign bus.Count    = count;
  assign bus.LapValue = lap_q;
  assign bus.Rollover = rollover_q;
  assign bus.LoadErr  = load_err_q;
  assign bus.AtMax    = bcd_all(PW'(count), BCD_MAX, DIGITS);
  assign bus.AtZero   = bcd_all(PW'(count), '0, DIGITS);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed scoreboard bench: one wrapping and one saturating four-digit counter.
module tb_bcd_updown_counter;

  typedef struct {
    int          sel;
    string       tag;
    logic [15:0] count;
    logic [15:0] lap;
    logic        roll;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;

  exp_t        sb[$];
  logic [15:0] cntExp[2];
  logic [15:0] lapExp[2];
  int          nAsserts = 0;
  int          nFails   = 0;

  bcd_updown_counter_if #(.DIGITS(4)) busA ();
  bcd_updown_counter_if #(.DIGITS(4)) busB ();

  bcd_updown_counter #(.DIGITS(4), .WRAP(1'b1)) dutA (
    .Clk   (clk),
    .Reset (reset),
    .bus   (busA)
  );

  bcd_updown_counter #(.DIGITS(4), .WRAP(1'b0)) dutB (
    .Clk   (clk),
    .Reset (reset),
    .bus   (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [15:0] obs, input logic [15:0] expv);
    nAsserts++;
    assert (obs === expv) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h, expected %h", name, obs, expv);
    end
  endtask

  task automatic driveBus(input int sel, input logic en, input logic up, input logic clr,
                          input logic ld, input logic [15:0] ldVal, input logic lap);
    busA.En = 1'b0; busA.Up = 1'b0; busA.Clear = 1'b0; busA.Load = 1'b0;
    busA.LoadVal = '0; busA.Lap = 1'b0;
    busB.En = 1'b0; busB.Up = 1'b0; busB.Clear = 1'b0; busB.Load = 1'b0;
    busB.LoadVal = '0; busB.Lap = 1'b0;
    if (sel == 0) begin
      busA.En = en; busA.Up = up; busA.Clear = clr; busA.Load = ld;
      busA.LoadVal = ldVal; busA.Lap = lap;
    end else if (sel == 1) begin
      busB.En = en; busB.Up = up; busB.Clear = clr; busB.Load = ld;
      busB.LoadVal = ldVal; busB.Lap = lap;
    end
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [15:0] c, l;
    logic        r, er, mx, z;
    if (sb.size() == 0) begin
      nAsserts++;
      nFails++;
      $display("[TB] FAIL scoreboard: observed empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    if (e.sel == 0) begin
      c = busA.Count; l = busA.LapValue; r = busA.Rollover;
      er = busA.LoadErr; mx = busA.AtMax; z = busA.AtZero;
    end else begin
      c = busB.Count; l = busB.LapValue; r = busB.Rollover;
      er = busB.LoadErr; mx = busB.AtMax; z = busB.AtZero;
    end
    cmp({e.tag, ".count"},    c,  e.count);
    cmp({e.tag, ".lap"},      l,  e.lap);
    cmp({e.tag, ".rollover"}, 16'(r),  16'(e.roll));
    cmp({e.tag, ".loaderr"},  16'(er), 16'(e.err));
    cmp({e.tag, ".atmax"},    16'(mx), 16'(e.count == 16'h9999));
    cmp({e.tag, ".atzero"},   16'(z),  16'(e.count == 16'h0000));
  endtask

  task automatic applyStimulus(input int sel, input logic en, input logic up, input logic clr,
                               input logic ld, input logic [15:0] ldVal, input logic lap,
                               input logic [15:0] expCount, input logic expRoll,
                               input logic expErr, input string tag);
    exp_t e;
    @(negedge clk);
    driveBus(sel, en, up, clr, ld, ldVal, lap);
    if (lap) lapExp[sel] = cntExp[sel];
    cntExp[sel] = expCount;
    e.sel = sel; e.tag = tag; e.count = expCount; e.lap = lapExp[sel];
    e.roll = expRoll; e.err = expErr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Both counters share the reset, so both must read back as freshly reset.
  task automatic resetCheck(input string tag);
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      cntExp[s] = '0;
      lapExp[s] = '0;
      e.sel = s; e.tag = tag; e.count = '0; e.lap = '0; e.roll = 1'b0; e.err = 1'b0;
      sb.push_back(e);
      checkOutput();
    end
  endtask

  task automatic midCycleReset(input string tag);
    @(negedge clk);
    driveBus(2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    #2 reset = 1'b1;
    #1 resetCheck(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    driveBus(2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 resetCheck("reset");
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] wrap up");
    applyStimulus(0, 0, 0, 0, 1, 16'h9998, 0, 16'h9998, 0, 0, "load9998");
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 0, 16'h9999, 0, 0, "up9999");
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, "upwrap");
    applyStimulus(0, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, "rollclr");

    $display("[TB] down borrow and wrap");
    applyStimulus(0, 0, 0, 0, 1, 16'h1000, 0, 16'h1000, 0, 0, "load1000");
    applyStimulus(0, 1, 0, 0, 0, 16'h0000, 0, 16'h0999, 0, 0, "borrow");
    applyStimulus(0, 0, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, "load0000");
    applyStimulus(0, 1, 0, 0, 0, 16'h0000, 0, 16'h9999, 1, 0, "downwrap");
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 16'h9999, 0, 0, "hold");

    $display("[TB] load validation and priority");
    applyStimulus(0, 0, 0, 0, 1, 16'h12A4, 0, 16'h1204, 0, 1, "badload");
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 16'h1204, 0, 0, "errclr");
    applyStimulus(0, 1, 1, 0, 1, 16'h0500, 0, 16'h0500, 0, 0, "ldoveren");
    applyStimulus(0, 1, 1, 1, 1, 16'h0777, 0, 16'h0000, 0, 0, "clrfirst");
    applyStimulus(0, 0, 0, 0, 1, 16'h0999, 0, 16'h0999, 0, 0, "load0999");
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 0, 16'h1000, 0, 0, "ripple");
    applyStimulus(0, 0, 1, 0, 0, 16'h0000, 0, 16'h1000, 0, 0, "enoff");

    $display("[TB] lap capture");
    applyStimulus(0, 0, 0, 0, 1, 16'h0057, 0, 16'h0057, 0, 0, "load0057");
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 1, 16'h0058, 0, 0, "lapstep");
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 0, 16'h0059, 0, 0, "laphold1");
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 0, 16'h0060, 0, 0, "laphold2");
    applyStimulus(0, 1, 0, 0, 0, 16'h0000, 0, 16'h0059, 0, 0, "down0059");

    $display("[TB] saturate");
    applyStimulus(1, 0, 0, 0, 1, 16'h9999, 0, 16'h9999, 0, 0, "satload9");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 1, 0, 0, 16'h0000, 0, 16'h9999, 0, 0, "satup");
    end
    applyStimulus(1, 0, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, "satload0");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, "satdown");
    end
    applyStimulus(1, 0, 0, 0, 1, 16'h0005, 0, 16'h0005, 0, 0, "satload5");
    applyStimulus(1, 1, 0, 0, 0, 16'h0000, 0, 16'h0004, 0, 0, "satstep");

    $display("[TB] async reset");
    applyStimulus(0, 0, 0, 0, 1, 16'h0437, 0, 16'h0437, 0, 0, "load0437");
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 1, 16'h0437, 0, 0, "lap0437");
    midCycleReset("midreset");
    applyStimulus(0, 0, 0, 0, 1, 16'h9999, 0, 16'h9999, 0, 0, "reload9");
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, "wrapagain");
    midCycleReset("cancelroll");
    applyStimulus(0, 1, 1, 0, 0, 16'h0000, 0, 16'h0001, 0, 0, "afterreset");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
